// File: rtl/gt8b10b_dw_64to32.sv
// 64-to-32 AXI-Stream width down-converter for the 8b10b GT transmit path; [63:32] goes out first.
// Latency: upper word valid one cycle after the beat is accepted, lower word the cycle after the upper word fires.
// Backpressure: the slave is ready only when idle or when the final word of a beat is leaving; master outputs hold while stalled.
module gt8b10b_dw_64to32 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_8b10b_64b_axis_data,
    input  logic [7:0]  i_8b10b_64b_axis_keep,
    input  logic        i_8b10b_64b_axis_valid,
    input  logic        i_8b10b_64b_axis_last,
    output logic        o_8b10b_64b_axis_ready,
    output logic [31:0] o_8b10b_32b_axis_data,
    output logic [3:0]  o_8b10b_32b_axis_keep,
    output logic        o_8b10b_32b_axis_valid,
    output logic        o_8b10b_32b_axis_last,
    input  logic        i_8b10b_32b_axis_ready,
    output logic        o_keep_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } state_t;

    state_t      state_q;

    // Lower half of the accepted beat, waiting behind the upper word
    logic [31:0] hold_data_q;
    logic [3:0]  hold_keep_q;
    logic        hold_last_q;
    logic        hold_has_lo_q;

    // Registered master-side outputs
    logic [31:0] out_data_q;
    logic [3:0]  out_keep_q;
    logic        out_last_q;
    logic        out_valid_q;
    logic        keep_err_q;

    logic        final_word;
    logic        in_ready;
    logic        in_fire;
    logic        out_fire;
    logic        in_has_lo;
    logic        in_drop;
    logic        in_bad;

    // The word on the bus is the last one of its beat: lower word, or an upper word with no lower half
    assign final_word = (state_q == ST_LO) || ((state_q == ST_HI) && !hold_has_lo_q);

    // Ready is combinational from the master ready so a new beat can follow the final word with no bubble
    assign in_ready = !i_rst && ((state_q == ST_IDLE) || (final_word && i_8b10b_32b_axis_ready));
    assign in_fire  = i_8b10b_64b_axis_valid && in_ready;
    assign out_fire = out_valid_q && i_8b10b_32b_axis_ready;

    // A last beat with an empty lower half carries only the upper word
    assign in_has_lo = !(i_8b10b_64b_axis_last && (i_8b10b_64b_axis_keep[3:0] == 4'h0));
    // A last beat with an empty upper half has nothing to send and is swallowed
    assign in_drop   = i_8b10b_64b_axis_last && (i_8b10b_64b_axis_keep[7:4] == 4'h0);
    assign in_bad    = in_drop || (!i_8b10b_64b_axis_last && (i_8b10b_64b_axis_keep != 8'hFF));

    // Sequencer: load upper word on accept, step to lower word, then idle or reload back-to-back
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            hold_data_q   <= 32'h0;
            hold_keep_q   <= 4'h0;
            hold_last_q   <= 1'b0;
            hold_has_lo_q <= 1'b0;
            out_data_q    <= 32'h0;
            out_keep_q    <= 4'h0;
            out_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            keep_err_q    <= 1'b0;
        end else begin
            keep_err_q <= 1'b0;
            if (in_fire) begin
                keep_err_q <= in_bad;
                if (!in_drop) begin
                    out_data_q    <= i_8b10b_64b_axis_data[63:32];
                    out_keep_q    <= i_8b10b_64b_axis_keep[7:4];
                    out_last_q    <= i_8b10b_64b_axis_last && !in_has_lo;
                    out_valid_q   <= 1'b1;
                    hold_data_q   <= i_8b10b_64b_axis_data[31:0];
                    hold_keep_q   <= i_8b10b_64b_axis_keep[3:0];
                    hold_last_q   <= i_8b10b_64b_axis_last;
                    hold_has_lo_q <= in_has_lo;
                    state_q       <= ST_HI;
                end else begin
                    // Dropped beat: whatever was on the bus has just fired (or nothing was there)
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            end else if (out_fire) begin
                if ((state_q == ST_HI) && hold_has_lo_q) begin
                    out_data_q <= hold_data_q;
                    out_keep_q <= hold_keep_q;
                    out_last_q <= hold_last_q;
                    state_q    <= ST_LO;
                end else begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            end
        end
    end

    assign o_8b10b_64b_axis_ready = in_ready;
    assign o_8b10b_32b_axis_data  = out_data_q;
    assign o_8b10b_32b_axis_keep  = out_keep_q;
    assign o_8b10b_32b_axis_valid = out_valid_q;
    assign o_8b10b_32b_axis_last  = out_last_q;
    assign o_keep_err             = keep_err_q;

endmodule

// File: tb/tb_gt8b10b_dw_64to32.sv
// Bench for the 64-to-32 down-converter: directed scenarios plus a randomized packet stream.
// Latency: n/a.
// Backpressure: master ready is driven by the bench, both fixed and random.
module tb_gt8b10b_dw_64to32;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_dat;
    logic [7:0]  s_keep;
    logic        s_vld;
    logic        s_last;
    logic        s_rdy;
    logic [31:0] m_dat;
    logic [3:0]  m_keep;
    logic        m_vld;
    logic        m_last;
    logic        m_rdy;
    logic        keep_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    always #5 clk = ~clk;

    gt8b10b_dw_64to32 dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_8b10b_64b_axis_data  (s_dat),
        .i_8b10b_64b_axis_keep  (s_keep),
        .i_8b10b_64b_axis_valid (s_vld),
        .i_8b10b_64b_axis_last  (s_last),
        .o_8b10b_64b_axis_ready (s_rdy),
        .o_8b10b_32b_axis_data  (m_dat),
        .o_8b10b_32b_axis_keep  (m_keep),
        .o_8b10b_32b_axis_valid (m_vld),
        .o_8b10b_32b_axis_last  (m_last),
        .i_8b10b_32b_axis_ready (m_rdy),
        .o_keep_err             (keep_err)
    );

    // Advance to just after the next rising edge
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_vld = 1'b1; s_dat = 64'h1234_5678_9ABC_DEF0; s_keep = 8'hFF; s_last = 1'b0; m_rdy = 1'b1;
        #1;
        checks++; if (s_rdy !== 1'b0) $display("FAIL reset_ready got %b want 0", s_rdy);
        if (s_rdy !== 1'b0) errors++;
        nxt();
        checks++;
        if (m_vld !== 1'b0 || m_dat !== 32'h0 || m_keep !== 4'h0 || m_last !== 1'b0 || keep_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got vld=%b dat=%h keep=%h last=%b err=%b want all zero", m_vld, m_dat, m_keep, m_last, keep_err);
        end
        rst = 1'b0; s_vld = 1'b0;
        #1;
        checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", s_rdy); end
        nxt();
    endtask

    task automatic test_basic();
        logic [63:0] beats [3];
        logic [31:0] words [6];
        int bi = 0;
        beats[0] = 64'h0001_0002_0003_0004; beats[1] = 64'h0005_0006_0007_0008; beats[2] = 64'h0009_000A_000B_000C;
        words[0] = 32'h0001_0002; words[1] = 32'h0003_0004; words[2] = 32'h0005_0006;
        words[3] = 32'h0007_0008; words[4] = 32'h0009_000A; words[5] = 32'h000B_000C;
        m_rdy = 1'b1; s_keep = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            s_vld  = (bi < 3);
            s_dat  = (bi < 3) ? beats[bi] : 64'h0;
            s_last = (bi == 2);
            #1;
            checks++;
            if (s_rdy !== ((i % 2) == 0)) begin errors++; $display("FAIL basic_ready cycle %0d got %b want %b", i, s_rdy, (i % 2) == 0); end
            if (s_vld && s_rdy) bi++;
            nxt();
            checks++;
            if (m_vld !== 1'b1 || m_dat !== words[i] || m_keep !== 4'hF || m_last !== (i == 5)) begin
                errors++;
                $display("FAIL basic_word %0d got vld=%b dat=%h keep=%h last=%b want 1 %h F %b", i, m_vld, m_dat, m_keep, m_last, words[i], i == 5);
            end
        end
        s_vld = 1'b0;
        nxt();
        checks++; if (m_vld !== 1'b0) begin errors++; $display("FAIL basic_idle got vld=%b want 0", m_vld); end
    endtask

    task automatic test_odd();
        m_rdy = 1'b1; s_vld = 1'b1; s_dat = 64'hAAAA_BBBB_CCCC_DDDD; s_keep = 8'hF0; s_last = 1'b1;
        #1;
        checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL odd_accept got %b want 1", s_rdy); end
        nxt();
        s_vld = 1'b0;
        #1;
        checks++;
        if (m_vld !== 1'b1 || m_dat !== 32'hAAAA_BBBB || m_keep !== 4'hF || m_last !== 1'b1) begin
            errors++;
            $display("FAIL odd_word got vld=%b dat=%h keep=%h last=%b want 1 AAAABBBB F 1", m_vld, m_dat, m_keep, m_last);
        end
        checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL odd_ready_reassert got %b want 1", s_rdy); end
        nxt();
        checks++; if (m_vld !== 1'b0) begin errors++; $display("FAIL odd_idle got vld=%b want 0", m_vld); end
    endtask

    task automatic test_partial();
        m_rdy = 1'b1; s_vld = 1'b1; s_dat = 64'hAAAA_BBBB_CCCC_DDDD; s_keep = 8'hFC; s_last = 1'b1;
        nxt();
        s_vld = 1'b0;
        #1;
        checks++;
        if (m_vld !== 1'b1 || m_dat !== 32'hAAAA_BBBB || m_keep !== 4'hF || m_last !== 1'b0 || s_rdy !== 1'b0) begin
            errors++;
            $display("FAIL partial_hi got vld=%b dat=%h keep=%h last=%b rdy=%b want 1 AAAABBBB F 0 0", m_vld, m_dat, m_keep, m_last, s_rdy);
        end
        nxt();
        checks++;
        if (m_vld !== 1'b1 || m_dat !== 32'hCCCC_DDDD || m_keep !== 4'hC || m_last !== 1'b1) begin
            errors++;
            $display("FAIL partial_lo got vld=%b dat=%h keep=%h last=%b want 1 CCCCDDDD C 1", m_vld, m_dat, m_keep, m_last);
        end
        nxt();
        checks++; if (m_vld !== 1'b0) begin errors++; $display("FAIL partial_idle got vld=%b want 0", m_vld); end
    endtask

    task automatic test_backpressure();
        logic [63:0] beats [2];
        logic [31:0] words [4];
        int bi = 0;
        int k = 0;
        beats[0] = 64'h1111_2222_3333_4444; beats[1] = 64'h5555_6666_7777_8888;
        words[0] = 32'h1111_2222; words[1] = 32'h3333_4444; words[2] = 32'h5555_6666; words[3] = 32'h7777_8888;
        m_rdy = 1'b0; s_vld = 1'b1; s_dat = beats[0]; s_keep = 8'hFF; s_last = 1'b0;
        nxt();
        bi = 1;
        for (int c = 0; c < 5; c++) begin
            s_dat = beats[1]; s_last = 1'b1;
            #1;
            checks++;
            if (s_rdy !== 1'b0 || m_vld !== 1'b1 || m_dat !== 32'h1111_2222 || m_keep !== 4'hF || m_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got rdy=%b vld=%b dat=%h keep=%h last=%b want 0 1 11112222 F 0", c, s_rdy, m_vld, m_dat, m_keep, m_last);
            end
            nxt();
        end
        m_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            s_vld = (bi < 2);
            #1;
            if (m_vld && m_rdy) begin
                checks++;
                if (k >= 4 || m_dat !== words[k] || m_keep !== 4'hF || m_last !== (k == 3)) begin
                    errors++;
                    $display("FAIL stall_release word %0d got dat=%h last=%b want %h %b", k, m_dat, m_last, (k < 4) ? words[k] : 32'h0, k == 3);
                end
                k++;
            end
            if (s_vld && s_rdy) bi++;
            nxt();
        end
        checks++; if (k !== 4) begin errors++; $display("FAIL stall_count got %0d words want 4", k); end
    endtask

    task automatic test_malformed();
        m_rdy = 1'b1; s_vld = 1'b1; s_dat = 64'hDEAD_BEEF_0BAD_F00D; s_keep = 8'h0F; s_last = 1'b1;
        nxt();
        s_vld = 1'b0;
        #1;
        checks++;
        if (keep_err !== 1'b1 || m_vld !== 1'b0 || s_rdy !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse got err=%b vld=%b rdy=%b want 1 0 1", keep_err, m_vld, s_rdy);
        end
        nxt();
        checks++;
        if (keep_err !== 1'b0 || m_vld !== 1'b0) begin errors++; $display("FAIL drop_after got err=%b vld=%b want 0 0", keep_err, m_vld); end

        s_vld = 1'b1; s_dat = 64'h0102_0304_0506_0708; s_keep = 8'h7F; s_last = 1'b0;
        nxt();
        s_dat = 64'h090A_0B0C_0D0E_0F10; s_keep = 8'hFF; s_last = 1'b1;
        checks++;
        if (keep_err !== 1'b1 || m_vld !== 1'b1 || m_dat !== 32'h0102_0304 || m_keep !== 4'h7 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL bad_keep_hi got err=%b vld=%b dat=%h keep=%h last=%b want 1 1 01020304 7 0", keep_err, m_vld, m_dat, m_keep, m_last);
        end
        nxt();
        checks++;
        if (keep_err !== 1'b0 || m_dat !== 32'h0506_0708 || m_keep !== 4'hF || m_last !== 1'b0) begin
            errors++;
            $display("FAIL bad_keep_lo got err=%b dat=%h keep=%h last=%b want 0 05060708 F 0", keep_err, m_dat, m_keep, m_last);
        end
        nxt();
        s_vld = 1'b0;
        checks++;
        if (keep_err !== 1'b0 || m_dat !== 32'h090A_0B0C || m_last !== 1'b0) begin
            errors++;
            $display("FAIL follow_hi got err=%b dat=%h last=%b want 0 090A0B0C 0", keep_err, m_dat, m_last);
        end
        nxt();
        checks++;
        if (m_vld !== 1'b1 || m_dat !== 32'h0D0E_0F10 || m_last !== 1'b1) begin
            errors++;
            $display("FAIL follow_lo got vld=%b dat=%h last=%b want 1 0D0E0F10 1", m_vld, m_dat, m_last);
        end
        nxt();
        checks++; if (m_vld !== 1'b0) begin errors++; $display("FAIL malformed_idle got vld=%b want 0", m_vld); end
    endtask

    task automatic test_mid_reset();
        m_rdy = 1'b1; s_vld = 1'b1; s_dat = 64'hCAFE_0001_CAFE_0002; s_keep = 8'hFF; s_last = 1'b0;
        nxt();
        s_vld = 1'b0;
        nxt();
        checks++;
        if (m_vld !== 1'b1 || m_dat !== 32'hCAFE_0002) begin errors++; $display("FAIL mid_pending got vld=%b dat=%h want 1 CAFE0002", m_vld, m_dat); end
        m_rdy = 1'b0; rst = 1'b1;
        #1;
        checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", s_rdy); end
        nxt();
        checks++;
        if (m_vld !== 1'b0 || m_dat !== 32'h0 || m_keep !== 4'h0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_out got vld=%b dat=%h keep=%h last=%b want 0 0 0 0", m_vld, m_dat, m_keep, m_last);
        end
        rst = 1'b0; m_rdy = 1'b1; s_vld = 1'b1; s_dat = 64'h5A5A_0001_5A5A_0002; s_keep = 8'hFF; s_last = 1'b1;
        #1;
        checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL mid_after_ready got %b want 1", s_rdy); end
        nxt();
        s_vld = 1'b0;
        checks++;
        if (m_vld !== 1'b1 || m_dat !== 32'h5A5A_0001 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_next_hi got vld=%b dat=%h last=%b want 1 5A5A0001 0", m_vld, m_dat, m_last);
        end
        nxt();
        checks++;
        if (m_vld !== 1'b1 || m_dat !== 32'h5A5A_0002 || m_last !== 1'b1) begin
            errors++;
            $display("FAIL mid_next_lo got vld=%b dat=%h last=%b want 1 5A5A0002 1", m_vld, m_dat, m_last);
        end
        nxt();
        checks++; if (m_vld !== 1'b0) begin errors++; $display("FAIL mid_idle got vld=%b want 0", m_vld); end
    endtask

    task automatic test_random();
        beat_t beats[$];
        word_t exp_q[$];
        beat_t b;
        word_t w;
        int n;
        int bi = 0;
        int cyc = 0;
        logic cur_vld = 1'b0;
        logic err_exp = 1'b0;
        logic stall = 1'b0;
        logic drop, has_lo;
        word_t prev;
        // Build packets of 1..4 beats with assorted legal and malformed keeps
        while (beats.size() < 300) begin
            int plen = $urandom_range(1, 4);
            for (int p = 0; p < plen; p++) begin
                b.d = {$urandom, $urandom};
                b.l = (p == plen - 1);
                if (!b.l) begin
                    b.k = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
                end else begin
                    case ($urandom_range(0, 7))
                        0: b.k = 8'hFF;
                        1: b.k = 8'hF0;
                        2: b.k = 8'hFC;
                        3: b.k = 8'hF8;
                        4: b.k = 8'hFE;
                        5: b.k = 8'h80;
                        6: b.k = 8'h0F;
                        default: b.k = 8'($urandom);
                    endcase
                end
                beats.push_back(b);
            end
        end
        n = beats.size();
        while ((bi < n || exp_q.size() > 0 || m_vld) && cyc < 6000) begin
            checks++;
            if (keep_err !== err_exp) begin errors++; $display("FAIL rand_keep_err cycle %0d got %b want %b", cyc, keep_err, err_exp); end
            if (stall) begin
                checks++;
                if (m_vld !== 1'b1 || m_dat !== prev.d || m_keep !== prev.k || m_last !== prev.l) begin
                    errors++;
                    $display("FAIL rand_stable cycle %0d got vld=%b dat=%h keep=%h last=%b want 1 %h %h %b", cyc, m_vld, m_dat, m_keep, m_last, prev.d, prev.k, prev.l);
                end
            end
            if (!cur_vld && bi < n) cur_vld = ($urandom_range(0, 3) != 0);
            s_vld = cur_vld;
            if (bi < n) begin
                s_dat = beats[bi].d; s_keep = beats[bi].k; s_last = beats[bi].l;
            end
            m_rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (m_vld && m_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_word got dat=%h want none", m_dat);
                end else begin
                    w = exp_q.pop_front();
                    if (m_dat !== w.d || m_keep !== w.k || m_last !== w.l) begin
                        errors++;
                        $display("FAIL rand_word got dat=%h keep=%h last=%b want %h %h %b", m_dat, m_keep, m_last, w.d, w.k, w.l);
                    end
                end
            end
            err_exp = 1'b0;
            if (s_vld && s_rdy) begin
                b = beats[bi];
                drop   = b.l && (b.k[7:4] == 4'h0);
                has_lo = !(b.l && (b.k[3:0] == 4'h0));
                err_exp = drop || (!b.l && (b.k != 8'hFF));
                if (!drop) begin
                    w.d = b.d[63:32]; w.k = b.k[7:4]; w.l = b.l && !has_lo;
                    exp_q.push_back(w);
                    if (has_lo) begin
                        w.d = b.d[31:0]; w.k = b.k[3:0]; w.l = b.l;
                        exp_q.push_back(w);
                    end
                end
                bi++;
                cur_vld = 1'b0;
            end
            stall  = m_vld && !m_rdy;
            prev.d = m_dat; prev.k = m_keep; prev.l = m_last;
            nxt();
            cyc++;
        end
        s_vld = 1'b0;
        checks++;
        if (keep_err !== err_exp) begin errors++; $display("FAIL rand_keep_err_final got %b want %b", keep_err, err_exp); end
        checks++;
        if (bi != n || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain got beats=%0d words_left=%0d want beats=%0d words_left=0", bi, exp_q.size(), n);
        end
    endtask

    initial begin
        s_vld = 1'b0; s_dat = 64'h0; s_keep = 8'h0; s_last = 1'b0; m_rdy = 1'b0; rst = 1'b1;
        test_reset();
        test_basic();
        test_odd();
        test_partial();
        test_backpressure();
        test_malformed();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
